// File: rtl/fp32_divider.sv
// Iterative IEEE-754 binary32 divider: restoring division, one quotient bit per
// cycle, round-to-nearest-even, subnormals flushed to zero on input and output.
module fp32_divider #(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        invalid,
    output logic        div_zero,
    output logic        overflow,
    output logic        underflow,
    output logic [1:0]  dbg_state
);

    // Handshake: start is honoured only in IDLE and not in the cycle done is
    // high; busy rises the cycle after acceptance and falls with the single
    // done pulse; result and flags then hold until the next accepted start.

    localparam int CW = $clog2(QBITS);
    localparam logic [CW-1:0] CNT_INIT = CW'(QBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_NORM   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [23:0]        mb_q;
    logic [24:0]        rem_q;
    logic [QBITS-1:0]   q_q;
    logic signed [9:0]  exp_q;
    logic               sign_q;
    logic [31:0]        pend_res_q;
    logic [3:0]         pend_flags_q;
    logic               busy_q;
    logic               done_q;
    logic [31:0]        result_q;
    logic [3:0]         flags_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign {invalid, div_zero, overflow, underflow} = flags_q;
    assign dbg_state = state_q;

    // Operand classification; exponent zero covers subnormals (flushed).
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic        sign_in;
    logic        spec_hit;
    logic [31:0] spec_res;
    logic [3:0]  spec_flags;

    assign ea     = input_a[30:23];
    assign eb     = input_b[30:23];
    assign fa     = input_a[22:0];
    assign fb     = input_b[22:0];
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'h0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'h0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'h0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'h0);
    assign sign_in = input_a[31] ^ input_b[31];

    always_comb begin
        spec_hit   = 1'b1;
        spec_res   = 32'h0;
        spec_flags = 4'b0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res   = 32'h7FC0_0000;
            spec_flags = 4'b1000;
        end else if (b_zero) begin
            spec_res   = {sign_in, 8'hFF, 23'h0};
            spec_flags = 4'b0100;
        end else if (a_inf) begin
            spec_res   = {sign_in, 8'hFF, 23'h0};
        end else if (a_zero || b_inf) begin
            spec_res   = {sign_in, 31'h0};
        end else begin
            spec_hit   = 1'b0;
        end
    end

    // One restoring step; the partial remainder stays below 2*divisor.
    logic        rem_ge;
    logic [24:0] rem_d;

    always_comb begin
        rem_ge = (rem_q >= {1'b0, mb_q});
        if (rem_ge) begin
            rem_d = (rem_q - {1'b0, mb_q}) << 1;
        end else begin
            rem_d = rem_q << 1;
        end
    end

    // Normalise, round to nearest even, then range-check the exponent.
    logic [QBITS-1:0]  qn;
    logic signed [9:0] en, en_r;
    logic [23:0]       sig;
    logic              guard, sticky, round_up;
    logic [24:0]       sig_rnd;
    logic [22:0]       frac_r;
    logic [31:0]       norm_res_d;
    logic [3:0]        norm_flags_d;

    always_comb begin
        if (q_q[QBITS-1]) begin
            qn = q_q;
            en = exp_q;
        end else begin
            qn = q_q << 1;
            en = exp_q - 10'sd1;
        end
        sig      = qn[QBITS-1 -: 24];
        guard    = qn[QBITS-25];
        // Bits below the guard (present only when no shift occurred) are sticky too.
        sticky   = (rem_q != 25'h0) || (|qn[QBITS-26:0]);
        round_up = guard & (sticky | sig[0]);
        sig_rnd  = {1'b0, sig} + {24'h0, round_up};
        if (sig_rnd[24]) begin
            frac_r = sig_rnd[23:1];
            en_r   = en + 10'sd1;
        end else begin
            frac_r = sig_rnd[22:0];
            en_r   = en;
        end
        norm_flags_d = 4'b0000;
        if (en_r >= 10'sd255) begin
            norm_res_d   = {sign_q, 8'hFF, 23'h0};
            norm_flags_d = 4'b0010;
        end else if (en_r <= 10'sd0) begin
            norm_res_d   = {sign_q, 31'h0};
            norm_flags_d = 4'b0001;
        end else begin
            norm_res_d   = {sign_q, en_r[7:0], frac_r};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mb_q         <= '0;
            rem_q        <= '0;
            q_q          <= '0;
            exp_q        <= '0;
            sign_q       <= 1'b0;
            pend_res_q   <= '0;
            pend_flags_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            flags_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !done_q) begin
                        busy_q  <= 1'b1;
                        flags_q <= 4'b0000;
                        sign_q  <= sign_in;
                        mb_q    <= {1'b1, fb};
                        rem_q   <= {2'b01, fa};
                        q_q     <= '0;
                        exp_q   <= 10'(ea) - 10'(eb) + 10'sd127;
                        cnt_q   <= CNT_INIT;
                        if (spec_hit) begin
                            pend_res_q   <= spec_res;
                            pend_flags_q <= spec_flags;
                            state_q      <= S_DONE;
                        end else begin
                            state_q      <= S_DIVIDE;
                        end
                    end
                end
                S_DIVIDE: begin
                    q_q   <= {q_q[QBITS-2:0], rem_ge};
                    rem_q <= rem_d;
                    if (cnt_q == '0) begin
                        state_q <= S_NORM;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_NORM: begin
                    pend_res_q   <= norm_res_d;
                    pend_flags_q <= norm_flags_d;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    result_q <= pend_res_q;
                    flags_q  <= pend_flags_q;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_divider.sv
// Bench for fp32_divider: directed vector table, handshake/reset sequences and
// random operands checked against an integer-arithmetic IEEE division model.
module tb_fp32_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] input_a = 32'h0;
    logic [31:0] input_b = 32'h0;
    logic        busy, done, invalid, div_zero, overflow, underflow;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    fp32_divider dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .input_a(input_a), .input_b(input_b),
        .busy(busy), .done(done), .result(result),
        .invalid(invalid), .div_zero(div_zero),
        .overflow(overflow), .underflow(underflow),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;   // {invalid, div_zero, overflow, underflow}
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact quotient from 64-bit integer division, then RNE.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
        logic        sg;
        logic [7:0]  ea, eb;
        logic        az, ai, an, bz, bi, bn;
        logic [63:0] num, qv, rv, sig, low_mask;
        int          e, s;
        logic        g, st;
        sg = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        az = (ea == 0); ai = (ea == 8'hFF) && (a[22:0] == 0); an = (ea == 8'hFF) && (a[22:0] != 0);
        bz = (eb == 0); bi = (eb == 8'hFF) && (b[22:0] == 0); bn = (eb == 8'hFF) && (b[22:0] != 0);
        f = 4'b0000;
        lat = 1;
        if (an || bn || (az && bz) || (ai && bi)) begin
            r = 32'h7FC0_0000; f = 4'b1000;
        end else if (bz) begin
            r = {sg, 8'hFF, 23'h0}; f = 4'b0100;
        end else if (ai) begin
            r = {sg, 8'hFF, 23'h0};
        end else if (az || bi) begin
            r = {sg, 31'h0};
        end else begin
            lat = 28;
            num = {40'h0, 1'b1, a[22:0]} << 39;
            qv  = num / {40'h0, 1'b1, b[22:0]};
            rv  = num % {40'h0, 1'b1, b[22:0]};
            e   = int'(ea) - int'(eb) + 127;
            if (qv[39]) s = 16;
            else begin s = 15; e = e - 1; end
            sig = qv >> s;
            g   = qv[s-1];
            low_mask = (64'd1 << (s - 1)) - 64'd1;
            st  = ((qv & low_mask) != 0) || (rv != 0);
            if (g && (st || sig[0])) sig = sig + 1;
            if (sig == 64'h100_0000) begin sig = sig >> 1; e = e + 1; end
            if (e >= 255) begin
                r = {sg, 8'hFF, 23'h0}; f = 4'b0010;
            end else if (e <= 0) begin
                r = {sg, 31'h0}; f = 4'b0001;
            end else begin
                r = {sg, 8'(e), sig[22:0]};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        int sel;
        logic [7:0] ex;
        sel = $urandom_range(0, 11);
        case (sel)
            0: return {1'($urandom_range(0, 1)), 31'h0};
            1: return {1'($urandom_range(0, 1)), 8'hFF, 23'h0};
            2: return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
            3: return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
            default: begin
                if (sel < 9) ex = 8'($urandom_range(100, 154));
                else         ex = 8'($urandom_range(1, 254));
                return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
            end
        endcase
    endfunction

    // Waits for done after the start edge, bounded, and checks the pulse shape.
    task automatic wait_done(input string tag, inout int lat, output logic [31:0] r, output logic [3:0] f);
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_done_seen"}, {31'h0, done}, 32'h1);
        check({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
        r = result;
        f = {invalid, div_zero, overflow, underflow};
        @(posedge clk); #1;
        check({tag, "_done_width"}, {31'h0, done}, 32'h0);
        check({tag, "_result_hold"}, result, r);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [3:0] f, output int lat);
        @(negedge clk);
        input_a = a;
        input_b = b;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        check({tag, "_busy_after_start"}, {31'h0, busy}, 32'h1);
        wait_done(tag, lat, r, f);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, er, ra, rb;
        logic [3:0]  f, ef;
        int          lat, elat, seen;

        vecs[0] = '{32'h40F0_0000, 32'h4020_0000, 32'h4040_0000, 4'b0000, 28};
        vecs[1] = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 28};
        vecs[2] = '{32'h40C0_0000, 32'hBFC0_0000, 32'hC080_0000, 4'b0000, 28};
        vecs[3] = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100, 1};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1};
        vecs[5] = '{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000, 1};
        vecs[6] = '{32'h7F7F_FFFF, 32'h3E80_0000, 32'h7F80_0000, 4'b0010, 28};
        vecs[7] = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0001, 28};
        vecs[8] = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 1};
        vecs[9] = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 1};

        #12;
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        check("reset_flags", {28'h0, invalid, div_zero, overflow, underflow}, 32'h0);
        check("reset_state", {30'h0, dbg_state}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, r, f, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_flags", i), {28'h0, f}, {28'h0, vecs[i].flags});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // start re-pulsed with different operands mid-division is ignored
        @(negedge clk);
        input_a = 32'h40F0_0000; input_b = 32'h4020_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 0;
        while (lat < 10) begin @(posedge clk); #1; lat++; end
        input_a = 32'h3F80_0000; input_b = 32'h0000_0000; start = 1'b1;
        @(posedge clk); #1;
        lat++;
        start = 1'b0; input_a = 32'h1234_5678; input_b = 32'h9ABC_DEF0;
        wait_done("repulse", lat, r, f);
        check("repulse_result", r, 32'h4040_0000);
        check("repulse_flags", {28'h0, f}, 32'h0);
        check("repulse_latency", 32'(lat), 32'd28);

        // start held through the done cycle is only taken in the following IDLE cycle
        @(negedge clk);
        input_a = 32'h3F80_0000; input_b = 32'h4040_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 0;
        while (done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
        check("hold_first_latency", 32'(lat), 32'd28);
        input_a = 32'h40C0_0000; input_b = 32'hBFC0_0000; start = 1'b1;
        @(posedge clk); #1;
        check("done_cycle_start_ignored", {31'h0, busy}, 32'h0);
        check("done_cycle_result_kept", result, 32'h3EAA_AAAB);
        @(posedge clk); #1;
        start = 1'b0; lat = 0;
        check("next_idle_start_taken", {31'h0, busy}, 32'h1);
        wait_done("after_done", lat, r, f);
        check("after_done_result", r, 32'hC080_0000);
        check("after_done_latency", 32'(lat), 32'd28);

        // asynchronous reset mid-division
        @(negedge clk);
        input_a = 32'h3F80_0000; input_b = 32'h4040_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'h0, busy}, 32'h0);
        check("midreset_result", result, 32'h0);
        check("midreset_state", {30'h0, dbg_state}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        check("midreset_no_done", 32'(seen), 32'd0);
        run_op("post_reset", 32'h40F0_0000, 32'h4020_0000, r, f, lat);
        check("post_reset_result", r, 32'h4040_0000);
        check("post_reset_latency", 32'(lat), 32'd28);

        for (int i = 0; i < 150; i++) begin
            ra = rand_op();
            rb = rand_op();
            model(ra, rb, er, ef, elat);
            run_op($sformatf("rnd%0d", i), ra, rb, r, f, lat);
            if (r !== er || f !== ef)
                $display("  rnd%0d operands a=%h b=%h", i, ra, rb);
            check($sformatf("rnd%0d_result", i), r, er);
            check($sformatf("rnd%0d_flags", i), {28'h0, f}, {28'h0, ef});
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/fp32_divider.md
Name: fp32_divider

Overview:
- Iterative IEEE-754 single-precision divider (result = input_a / input_b); the inverse-operation companion to the combinational multiplier.
- Sits alongside the multiplier in the FP datapath and is driven by a start/done handshake.
- Produces one quotient bit per cycle with round-to-nearest-even.
- Subnormals are flushed to zero on input and on output, matching the multiplier's FTZ convention.

Parameters:
- QBITS, 26, quotient bits generated: 24 significand bits + 1 normalisation bit + 1 guard bit. Sticky comes from the final remainder.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- input_a  input  32  dividend, IEEE-754 binary32
- input_b  input  32  divisor, IEEE-754 binary32
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  single-cycle pulse; result/flags valid from this cycle
- result  output  32  quotient, held until the next accepted start
- invalid  output  1  0/0, inf/inf, or NaN operand
- div_zero  output  1  finite nonzero / zero
- overflow  output  1  rounded result exceeds max finite
- underflow  output  1  result flushed to zero

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, result=32'h0, all flags 0.
  - Reset mid-operation abandons the division; there is no done pulse.
- States: IDLE -> DIVIDE -> NORM -> DONE -> IDLE. Special cases go IDLE -> DONE.
- IDLE:
  - On start=1, latch operands and compute sign = sa^sb.
  - Classify operands as zero (exp=0, including subnormals), inf, NaN, or normal.
  - Clear all flags.
- Special cases (go straight to DONE, so done is high 2 edges after start):
  - Any NaN, 0/0, or inf/inf: result = 32'h7FC00000, invalid=1.
  - Finite nonzero / 0: result = {sign, 8'hFF, 23'h0}, div_zero=1.
  - inf / finite: result = {sign, inf}.
  - 0 / nonzero, or finite / inf: result = {sign, 31'h0}.
- DIVIDE:
  - Initialise: ma={1,fa}, mb={1,fb} (24b); remainder = ma; exp = ea - eb + 127 held as 10-bit signed.
  - Per cycle (restoring): if rem >= mb then q bit = 1 and rem -= mb, else q bit = 0; then rem <<= 1.
  - Runs exactly QBITS cycles, driven by a down-counter.
- NORM (1 cycle):
  - If q[25]=0, shift q left 1 and exp -= 1.
  - Take 24-bit significand, guard bit, sticky = (rem != 0).
  - RNE: increment when guard & (sticky | lsb).
  - If rounding carries out, shift right and exp += 1.
  - exp >= 255: result = signed inf, overflow=1.
  - exp <= 0: result = signed zero, underflow=1.
- DONE:
  - Assert done for 1 cycle and drive result/flags.
  - busy drops in this same cycle.
  - Return to IDLE.
- Latency:
  - Normal operands: done is high exactly QBITS+2 = 28 cycles after the start edge.
  - Special cases: 1 cycle.
- Handshake and hold:
  - start while busy is ignored; operands changing while busy have no effect.
  - start asserted in the done cycle is ignored; it is accepted from the next IDLE cycle.
  - result and flags hold after done until the next accepted start.

Test Plan:
- 0x40F00000 (7.5) / 0x40200000 (2.5) -> result 0x40400000 at exactly 28 cycles after start; done 1 cycle wide; no flags.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (RNE round-up); 0x40C00000 / 0xBFC00000 (6/-1.5) -> 0xC0800000.
- Specials:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, div_zero=1.
  - 0/0 -> 0x7FC00000, invalid=1.
  - 0x7F800000 / 0x7F800000 -> 0x7FC00000, invalid=1.
  - Each has done 2 edges after start.
- Range:
  - 0x7F7FFFFF / 0x3E800000 -> 0x7F800000, overflow=1.
  - 0x00800000 / 0x40000000 -> 0x00000000, underflow=1.
  - Subnormal input 0x00000001 / 0x3F800000 -> 0x00000000.
- start re-pulsed with new operands at cycle 10 of a division -> ignored; original quotient delivered at cycle 28. rst_n pulsed low at cycle 15 -> busy=0 and result=0 immediately, no done pulse, next start works normally.
